bpu_btb_ras: RTL and testbench

- Parametrised branch prediction unit for the in-order RISC-V core.
- Combines a direct-mapped, tagged BTB, per-entry saturating direction counters and a return address stack (RAS).
- IF stage queries it combinationally with pc_f. EX resolution (registered one cycle, as the core already does for pc_e/pcplus4_e) trains it.
- Supersedes the fixed single-mode predictor: configurable depth, tag width, counter width and call/return prediction.

---
 rtl/bpu_btb_ras.sv | 199 +++++++++++++++++++
 tb/tb_bpu_btb_ras.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_btb_ras.sv
// Branch prediction unit: direct-mapped tagged BTB, per-entry saturating direction counters, return address stack.
// Latency: prediction is combinational from pc_f (0 cycles); training is committed on the clock edge that samples cflow_valid.
// Backpressure: none; one resolution per cycle is always accepted, and the first edge after reset release ignores its resolution.
module bpu_btb_ras #(
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  pc_f,
  output logic                         pred_taken,
  output logic [31:0]                  pred_target,
  input  logic [31:0]                  pc_e,
  input  logic [31:0]                  pcplus4_e,
  input  logic                         cflow_valid,
  input  logic                         cflow_taken,
  input  logic [31:0]                  cflow_target,
  input  logic                         cflow_is_jump,
  input  logic                         cflow_is_call,
  input  logic                         cflow_is_ret,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + 1 + TAG_W;
  localparam int PTR_W  = $clog2(RAS_DEPTH);
  localparam int RC_W   = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_ONE << (CNT_W - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [RC_W-1:0]  RC_ZERO  = '0;
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic [RC_W-1:0]  RC_FULL  = RC_W'(RAS_DEPTH);

  // BTB storage; valid/cnt/is_ret are reset, tags and targets are qualified by valid.
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] is_ret_q;
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  // Return stack: ras_ptr is the next write slot, the top entry lives at ras_ptr-1.
  logic [31:0]        ras_mem  [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr;
  logic [PTR_W-1:0]   ras_top;

  // Set by reset, cleared by the first clock edge after release so that edge trains nothing.
  logic               rst_hold;

  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic [31:0]        pc_f_p4;

  logic [IDX_W-1:0]   up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  logic               up_en;
  logic [CNT_W-1:0]   cnt_cur;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               cnt_wr;
  logic               ent_wr;

  logic               unused_pc_bits;

  assign unused_pc_bits = ^{pc_f[1:0], pc_f[31:TAG_HI+1], pc_e[1:0], pc_e[31:TAG_HI+1]};

  assign lk_idx  = pc_f[IDX_W+1:2];
  assign lk_tag  = pc_f[TAG_HI:TAG_LO];
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pc_f_p4 = pc_f + 32'd4;
  assign ras_top = ras_ptr - PTR_ONE;

  assign up_idx  = pc_e[IDX_W+1:2];
  assign up_tag  = pc_e[TAG_HI:TAG_LO];
  assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en   = cflow_valid && !rst_hold && !rst;

  // Lookup: returns use the stack top while it holds entries, otherwise the stored target.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_f_p4;
    if (!rst && lk_hit) begin
      if (is_ret_q[lk_idx] && (ras_count != RC_ZERO)) begin
        pred_taken  = 1'b1;
        pred_target = ras_mem[ras_top];
      end else if (is_ret_q[lk_idx] || cnt_q[lk_idx][CNT_W-1]) begin
        pred_taken  = 1'b1;
        pred_target = target_q[lk_idx];
      end
    end
  end

  // Training decision: next counter value and which fields of the indexed entry get written.
  always_comb begin
    cnt_cur = cnt_q[up_idx];
    cnt_nxt = cnt_cur;
    cnt_wr  = 1'b0;
    ent_wr  = 1'b0;
    if (up_en) begin
      if (up_hit) begin
        cnt_wr = 1'b1;
        if (cflow_taken) begin
          ent_wr = 1'b1;
          if (cflow_is_jump) begin
            cnt_nxt = CNT_MAX;
          end else if (cnt_cur != CNT_MAX) begin
            cnt_nxt = cnt_cur + CNT_ONE;
          end
        end else if (cnt_cur != CNT_ZERO) begin
          cnt_nxt = cnt_cur - CNT_ONE;
        end
      end else if (cflow_taken) begin
        cnt_wr  = 1'b1;
        ent_wr  = 1'b1;
        cnt_nxt = cflow_is_jump ? CNT_MAX : CNT_WEAK;
      end
    end
  end

  // Reset-release guard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_hold <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
    end
  end

  // BTB control state: valid, direction counter, return flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      is_ret_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      if (cnt_wr) begin
        cnt_q[up_idx] <= cnt_nxt;
      end
      if (ent_wr) begin
        valid_q[up_idx]  <= 1'b1;
        is_ret_q[up_idx] <= cflow_is_ret;
      end
    end
  end

  // BTB payload: tag and target, written on a taken resolution (same tag rewritten on a hit).
  always_ff @(posedge clk) begin
    if (ent_wr) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= cflow_target;
    end
  end

  // Stack pointer and occupancy: push saturates by overwriting the oldest slot, pop on empty is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (up_en) begin
      if (cflow_is_call && cflow_is_ret) begin
        if (ras_count == RC_ZERO) begin
          ras_ptr   <= ras_ptr + PTR_ONE;
          ras_count <= RC_ONE;
        end
      end else if (cflow_is_call) begin
        ras_ptr <= ras_ptr + PTR_ONE;
        if (ras_count != RC_FULL) begin
          ras_count <= ras_count + RC_ONE;
        end
      end else if (cflow_is_ret) begin
        if (ras_count != RC_ZERO) begin
          ras_ptr   <= ras_ptr - PTR_ONE;
          ras_count <= ras_count - RC_ONE;
        end
      end
    end
  end

  // Stack contents: call writes the next slot; call+ret replaces the top (or pushes when empty).
  always_ff @(posedge clk) begin
    if (up_en && cflow_is_call) begin
      if (cflow_is_ret && (ras_count != RC_ZERO)) begin
        ras_mem[ras_top] <= pcplus4_e;
      end else begin
        ras_mem[ras_ptr] <= pcplus4_e;
      end
    end
  end

endmodule

// File: tb/tb_bpu_btb_ras.sv
// Self-checking bench for bpu_btb_ras: directed scenarios followed by randomized traffic against a behavioural model.
// Latency: predictions sampled 1ns after pc_f changes; model trained at each rising edge.
// Backpressure: none; the bench drives at most one resolution per cycle.
module tb_bpu_btb_ras;

  localparam int ENTRIES   = 16;
  localparam int TAG_W     = 8;
  localparam int CNT_W     = 2;
  localparam int RAS_DEPTH = 4;
  localparam int IDX_W     = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;
  localparam int CWEAK     = 1 << (CNT_W - 1);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f = 32'h0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pc_e = 32'h0;
  logic [31:0] pcplus4_e = 32'h0;
  logic        cflow_valid = 1'b0;
  logic        cflow_taken = 1'b0;
  logic [31:0] cflow_target = 32'h0;
  logic        cflow_is_jump = 1'b0;
  logic        cflow_is_call = 1'b0;
  logic        cflow_is_ret = 1'b0;
  logic [2:0]  ras_count;

  bpu_btb_ras #(
    .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken(pred_taken), .pred_target(pred_target),
    .pc_e(pc_e), .pcplus4_e(pcplus4_e), .cflow_valid(cflow_valid), .cflow_taken(cflow_taken),
    .cflow_target(cflow_target), .cflow_is_jump(cflow_is_jump), .cflow_is_call(cflow_is_call),
    .cflow_is_ret(cflow_is_ret), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  bit          m_ret   [ENTRIES];
  logic [31:0] m_ras   [$];
  bit          m_hold;

  function automatic int idx_of(input logic [31:0] pc);
    int unsigned u;
    u = pc;
    return int'((u / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    int unsigned u;
    u = pc;
    return (u / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 0;
      m_ret[i]   = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
    end
    m_ras.delete();
    m_hold = 1;
  endtask

  task automatic model_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i;
    i  = idx_of(pc);
    tk = 1'b0;
    tg = pc + 32'd4;
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      if (m_ret[i] && m_ras.size() > 0) begin
        tk = 1'b1;
        tg = m_ras[m_ras.size() - 1];
      end else if (m_ret[i] || m_cnt[i] >= CWEAK) begin
        tk = 1'b1;
        tg = m_tgt[i];
      end
    end
  endtask

  task automatic model_update();
    int  i;
    bit  hit;
    i   = idx_of(pc_e);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc_e));
    if (hit) begin
      if (cflow_taken) begin
        m_cnt[i] = cflow_is_jump ? CMAX : ((m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1);
        m_tgt[i] = cflow_target;
        m_ret[i] = cflow_is_ret;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end else if (cflow_taken) begin
      m_valid[i] = 1;
      m_tag[i]   = tag_of(pc_e);
      m_tgt[i]   = cflow_target;
      m_cnt[i]   = cflow_is_jump ? CMAX : CWEAK;
      m_ret[i]   = cflow_is_ret;
    end
    if (cflow_is_call && cflow_is_ret) begin
      if (m_ras.size() == 0) m_ras.push_back(pcplus4_e);
      else m_ras[m_ras.size() - 1] = pcplus4_e;
    end else if (cflow_is_call) begin
      m_ras.push_back(pcplus4_e);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end else if (cflow_is_ret) begin
      if (m_ras.size() > 0) void'(m_ras.pop_back());
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model trains on what the DUT samples, then inputs return to idle at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (!m_hold && cflow_valid) model_update();
      m_hold = 0;
    end
    @(negedge clk);
    cflow_valid = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] p4, input bit tk,
                         input logic [31:0] tg, input bit jmp, input bit call, input bit ret);
    pc_e          = pc;
    pcplus4_e     = p4;
    cflow_valid   = 1'b1;
    cflow_taken   = tk;
    cflow_target  = tg;
    cflow_is_jump = jmp;
    cflow_is_call = call;
    cflow_is_ret  = ret;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] p4, input bit tk,
                     input logic [31:0] tg, input bit jmp, input bit call, input bit ret);
    set_upd(pc, p4, tk, tg, jmp, call, ret);
    tick();
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    pc_f = pc;
    #1;
    chk({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, tk});
    chk({tag, ".target"}, pred_target, tg);
  endtask

  task automatic look_ras(input string tag, input int n);
    chk({tag, ".ras_count"}, {29'b0, ras_count}, n);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = ($urandom_range(4, 7) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 3) == 0) pc = pc | ($urandom & 32'hFFFFC000);
    return pc;
  endfunction

  initial begin
    logic        e_tk;
    logic [31:0] e_tg;
    int          kind;

    // 1. Reset state and pc+4 wrap.
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    look("rst_pc100", 32'h100, 0, 32'h104);
    look_ras("rst", 0);
    look("rst_wrap", 32'hFFFF_FFFC, 0, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // 2. Direction training; lookup in the update cycle sees the old state.
    set_upd(32'h100, 32'h104, 1, 32'h80, 0, 0, 0);
    look("same_cycle", 32'h100, 0, 32'h104);
    tick();
    look("cnt2", 32'h100, 1, 32'h80);
    upd(32'h100, 32'h104, 1, 32'h80, 0, 0, 0);
    upd(32'h100, 32'h104, 1, 32'h80, 0, 0, 0);
    look("cnt3_sat", 32'h100, 1, 32'h80);
    upd(32'h100, 32'h104, 0, 32'h0, 0, 0, 0);
    look("nt_cnt2", 32'h100, 1, 32'h80);
    upd(32'h100, 32'h104, 0, 32'h0, 0, 0, 0);
    look("nt_cnt1", 32'h100, 0, 32'h104);
    upd(32'h100, 32'h104, 0, 32'h0, 0, 0, 0);
    upd(32'h100, 32'h104, 0, 32'h0, 0, 0, 0);
    upd(32'h100, 32'h104, 1, 32'h80, 0, 0, 0);
    look("floor_then_t", 32'h100, 0, 32'h104);

    // 3. Aliasing and non-allocating cases.
    upd(32'h100, 32'h104, 1, 32'h80, 0, 0, 0);
    look("retrain", 32'h100, 1, 32'h80);
    upd(32'h140, 32'h144, 1, 32'h500, 0, 0, 0);
    look("alias_new", 32'h140, 1, 32'h500);
    look("alias_old", 32'h100, 0, 32'h104);
    upd(32'h180, 32'h184, 0, 32'h0, 0, 0, 0);
    look("miss_nt", 32'h180, 0, 32'h184);
    look("miss_nt_keep", 32'h140, 1, 32'h500);
    set_upd(32'h180, 32'h184, 1, 32'h999, 1, 1, 0);
    cflow_valid = 1'b0;
    tick();
    look("novalid", 32'h180, 0, 32'h184);
    look_ras("novalid", 0);

    // 4. Call/return.
    upd(32'h200, 32'h204, 1, 32'h400, 1, 1, 0);
    look_ras("call1", 1);
    upd(32'h410, 32'h414, 1, 32'h204, 1, 0, 1);
    look_ras("ret1", 0);
    look("ret_empty", 32'h410, 1, 32'h204);
    upd(32'h300, 32'h304, 1, 32'h400, 1, 1, 0);
    look("ret_ras", 32'h410, 1, 32'h304);
    look_ras("call2", 1);
    upd(32'h410, 32'h414, 1, 32'h204, 1, 0, 1);

    // 5. Overflow, underflow, call+ret.
    for (int k = 1; k <= 5; k++) upd(32'h600, 32'(k * 16), 1, 32'h400, 1, 1, 0);
    look_ras("ovf", 4);
    for (int k = 5; k >= 2; k--) begin
      look($sformatf("pop%0d", k), 32'h410, 1, 32'(k * 16));
      upd(32'h410, 32'h414, 1, 32'h204, 1, 0, 1);
    end
    look_ras("pop4", 0);
    upd(32'h410, 32'h414, 1, 32'h204, 1, 0, 1);
    look_ras("unf", 0);
    look("unf_stored", 32'h410, 1, 32'h204);
    upd(32'h600, 32'h30, 1, 32'h400, 1, 1, 0);
    upd(32'h600, 32'h40, 1, 32'h400, 1, 1, 0);
    upd(32'h410, 32'h60, 1, 32'h204, 1, 1, 1);
    look("callret_top", 32'h410, 1, 32'h60);
    look_ras("callret", 2);
    upd(32'h410, 32'h414, 1, 32'h204, 1, 0, 1);
    look("callret_pop", 32'h410, 1, 32'h30);
    upd(32'h410, 32'h414, 1, 32'h204, 1, 0, 1);
    upd(32'h410, 32'h70, 1, 32'h204, 1, 1, 1);
    look("callret_empty", 32'h410, 1, 32'h70);
    look_ras("callret_empty", 1);

    // 6. Reset mid-stream with a live update, and an update coincident with release.
    set_upd(32'h410, 32'h414, 1, 32'h888, 1, 0, 1);
    rst = 1'b1;
    model_reset();
    look("mid_rst", 32'h410, 0, 32'h414);
    look_ras("mid_rst", 0);
    tick();
    set_upd(32'h600, 32'h604, 1, 32'h900, 1, 0, 0);
    rst = 1'b0;
    tick();
    look("post_410", 32'h410, 0, 32'h414);
    look("post_600", 32'h600, 0, 32'h604);
    look("post_140", 32'h140, 0, 32'h144);
    look_ras("post", 0);
    upd(32'h600, 32'h604, 1, 32'h900, 0, 0, 0);
    look("post_train", 32'h600, 1, 32'h900);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      kind = $urandom_range(0, 5);
      set_upd(rand_pc(), $urandom & 32'hFFFFFFFC, 1, $urandom, 1, 0, 0);
      case (kind)
        0, 1: begin cflow_taken = 1'($urandom_range(0, 1)); cflow_is_jump = 1'b0; end
        3: cflow_is_call = 1'b1;
        4: cflow_is_ret = 1'b1;
        5: begin cflow_is_call = 1'b1; cflow_is_ret = 1'b1; end
        default: ;
      endcase
      cflow_valid = ($urandom_range(0, 3) != 0);
      pc_f = rand_pc();
      #1;
      model_pred(pc_f, e_tk, e_tg);
      chk("rand.taken", {31'b0, pred_taken}, {31'b0, e_tk});
      chk("rand.target", pred_target, e_tg);
      chk("rand.ras_count", {29'b0, ras_count}, m_ras.size());
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
